// File: rtl/sram_responder_if.sv
// ============================================================================
// sram_responder_if : CPU-side SRAM access bus (request + one-cycle response)
// Revision 1.0
// ============================================================================
`default_nettype none

interface sram_responder_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        err_oor;
    logic [15:0] oor_count;

    modport master (
        output en, wen, addr, wdata,
        input  rdata, busy, err_oor, oor_count
    );

    modport slave (
        input  en, wen, addr, wdata,
        output rdata, busy, err_oor, oor_count
    );
endinterface

`default_nettype wire

// File: rtl/sram_responder.sv
// ============================================================================
// sram_responder : single-port word SRAM slave, fixed 1-cycle latency, byte
// lanes, window decode, OOR reporting, zero-clear sweep after reset.
// Optional macro SRAM_WRITE_FIRST_EN selects write-first read data.
// Revision 1.0
// ============================================================================
`default_nettype none

module sram_responder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] OOR_DATA  = 32'hDEAD_BEEF
) (
    input  wire logic      clk,
    input  wire logic      rst,
    sram_responder_if.slave bus
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_idx = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [31:0]       r_rdata;
    logic              r_err_oor;
    logic [15:0]       r_oor_count;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] w_word;
    logic              w_in_range;
    logic              w_access;
    logic              w_acc_wr;
    logic [1:0]        w_unused_addr_lsb;

    assign w_word            = bus.addr[ADDR_W+1:2];
    assign w_in_range        = (bus.addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign w_unused_addr_lsb = bus.addr[1:0];
    // An access issued in the same cycle as rst is dropped entirely.
    assign w_access          = (r_state == S_READY) && bus.en && !rst;
    assign w_acc_wr          = w_access && w_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_idx == c_last_idx) w_state_next = S_READY;
            S_READY: w_state_next = S_READY;
            default: w_state_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    // Storage has no reset; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            mem[r_clr_idx] <= '0;
        end else if (w_acc_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wen[i]) mem[w_word][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

`ifdef SRAM_WRITE_FIRST_EN
    logic [31:0] w_rd_word;
    always_comb begin
        w_rd_word = mem[w_word];
        for (int i = 0; i < 4; i++) begin
            if (bus.wen[i]) w_rd_word[8*i +: 8] = bus.wdata[8*i +: 8];
        end
    end
`else
    logic [31:0] w_rd_word;
    assign w_rd_word = mem[w_word];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata     <= '0;
            r_err_oor   <= 1'b0;
            r_oor_count <= '0;
        end else begin
            r_err_oor <= 1'b0;
            if (w_access) begin
                if (w_in_range) begin
                    r_rdata <= w_rd_word;
                end else begin
                    r_rdata   <= OOR_DATA;
                    r_err_oor <= 1'b1;
                    if (r_oor_count != 16'hFFFF) r_oor_count <= r_oor_count + 16'd1;
                end
            end
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.busy      = (r_state == S_CLEAR);
    assign bus.err_oor   = r_err_oor;
    assign bus.oor_count = r_oor_count;

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
// ============================================================================
// tb_sram_responder : directed self-checking bench, ADDR_W=4, BASE_ADDR=0
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sram_responder;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    sram_responder_if bus ();

    sram_responder #(
        .ADDR_W   (4),
        .BASE_ADDR(32'h0000_0000),
        .OOR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d);
        bus.en    = e;
        bus.wen   = w;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
    endtask

    // Count cycles until busy falls; a stuck sweep returns the bound.
    task automatic wait_sweep(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            cyc();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        cyc();
        cyc();
        vectors++;
        if (bus.busy !== 1'b1 || bus.rdata !== 32'h0 || bus.err_oor !== 1'b0 ||
            bus.oor_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b rdata=%h err=%b cnt=%h, want 1/0/0/0",
                     bus.busy, bus.rdata, bus.err_oor, bus.oor_count);
        end
        rst = 1'b0;
        // Writes attempted during the sweep must be ignored.
        drive(1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF);
        wait_sweep(n);
        vectors++;
        if (n !== 16) begin
            miscompares++;
            $display("FAIL sweep_len: got %0d cycles, want 16", n);
        end
        vectors++;
        if (bus.rdata !== 32'h0 || bus.err_oor !== 1'b0 || bus.oor_count !== 16'h0) begin
            miscompares++;
            $display("FAIL busy_ignore: rdata=%h err=%b cnt=%h, want 0/0/0",
                     bus.rdata, bus.err_oor, bus.oor_count);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_clear_reads();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'h0, 32'(i * 4), 32'h0);
            cyc();
            vectors++;
            if (bus.rdata !== 32'h0) begin
                miscompares++;
                $display("FAIL clear_read[%0d]: got %h, want 00000000", i, bus.rdata);
            end
        end
        idle();
    endtask

    task automatic test_byte_lanes();
        logic [31:0] exp_wr;
        drive(1'b1, 4'hF, 32'h8, 32'h1122_3344);
        cyc();
        drive(1'b1, 4'b0101, 32'h8, 32'hAABB_CCDD);
        cyc();
`ifdef SRAM_WRITE_FIRST_EN
        exp_wr = 32'h11BB_33DD;
`else
        exp_wr = 32'h1122_3344;
`endif
        vectors++;
        if (bus.rdata !== exp_wr) begin
            miscompares++;
            $display("FAIL lane_write_rdata: got %h, want %h", bus.rdata, exp_wr);
        end
        drive(1'b1, 4'h0, 32'h8, 32'h0);
        cyc();
        vectors++;
        if (bus.rdata !== 32'h11BB_33DD) begin
            miscompares++;
            $display("FAIL lane_read: got %h, want 11bb33dd", bus.rdata);
        end
        drive(1'b1, 4'h0, 32'hB, 32'h0);
        cyc();
        vectors++;
        if (bus.rdata !== 32'h11BB_33DD) begin
            miscompares++;
            $display("FAIL lane_alias: got %h, want 11bb33dd", bus.rdata);
        end
        idle();
    endtask

    task automatic test_write_read();
        logic [31:0] exp_wr;
        drive(1'b1, 4'hF, 32'h10, 32'hCAFE_F00D);
        cyc();
`ifdef SRAM_WRITE_FIRST_EN
        exp_wr = 32'hCAFE_F00D;
`else
        exp_wr = 32'h0;
`endif
        vectors++;
        if (bus.rdata !== exp_wr) begin
            miscompares++;
            $display("FAIL wr_rdata: got %h, want %h", bus.rdata, exp_wr);
        end
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        cyc();
        vectors++;
        if (bus.rdata !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL wr_then_rd: got %h, want cafef00d", bus.rdata);
        end
        idle();
        vectors++;
        if (bus.rdata !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL idle_hold: got %h, want cafef00d", bus.rdata);
        end
    endtask

    task automatic test_oor();
        drive(1'b1, 4'hF, 32'h40, 32'h1234_5678);
        cyc();
        vectors++;
        if (bus.rdata !== 32'hDEAD_BEEF || bus.err_oor !== 1'b1 || bus.oor_count !== 16'd1) begin
            miscompares++;
            $display("FAIL oor_access: rdata=%h err=%b cnt=%h, want deadbeef/1/0001",
                     bus.rdata, bus.err_oor, bus.oor_count);
        end
        idle();
        vectors++;
        if (bus.err_oor !== 1'b0 || bus.rdata !== 32'hDEAD_BEEF || bus.oor_count !== 16'd1) begin
            miscompares++;
            $display("FAIL oor_pulse: err=%b rdata=%h cnt=%h, want 0/deadbeef/0001",
                     bus.err_oor, bus.rdata, bus.oor_count);
        end
        drive(1'b1, 4'h0, 32'h0, 32'h0);
        cyc();
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_no_write: word0=%h, want 00000000", bus.rdata);
        end
        // Drive the counter up to FFFE through real OOR reads.
        drive(1'b1, 4'h0, 32'h8000_0000, 32'h0);
        for (int i = 0; i < 65533; i++) cyc();
        vectors++;
        if (bus.oor_count !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL oor_cnt_fffe: got %h, want fffe", bus.oor_count);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++;
            if (bus.oor_count !== 16'hFFFF || bus.err_oor !== 1'b1) begin
                miscompares++;
                $display("FAIL oor_saturate[%0d]: cnt=%h err=%b, want ffff/1",
                         i, bus.oor_count, bus.err_oor);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'hF, 32'(i * 4), 32'h5A00_0000 + 32'(i * 32'h0001_0101));
            cyc();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'h0, 32'(i * 4), 32'h0);
            cyc();
            vectors++;
            if (bus.rdata !== 32'h5A00_0000 + 32'(i * 32'h0001_0101)) begin
                miscompares++;
                $display("FAIL stream_rd[%0d]: got %h, want %h", i, bus.rdata,
                         32'h5A00_0000 + 32'(i * 32'h0001_0101));
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wait_sweep(n);
        vectors++;
        if (n !== 16) begin
            miscompares++;
            $display("FAIL mid_sweep_len: got %0d cycles, want 16", n);
        end
        drive(1'b1, 4'h0, 32'h3C, 32'h0);
        cyc();
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_sweep_clear: word15=%h, want 00000000", bus.rdata);
        end
        idle();
    endtask

    task automatic test_reset_after_data();
        int n;
        drive(1'b1, 4'hF, 32'h4, 32'h5555_AAAA);
        cyc();
        drive(1'b1, 4'h0, 32'h100, 32'h0);
        cyc();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wait_sweep(n);
        drive(1'b1, 4'h0, 32'h4, 32'h0);
        cyc();
        vectors++;
        if (n !== 16 || bus.rdata !== 32'h0 || bus.oor_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_after_data: sweep=%0d rdata=%h cnt=%h, want 16/0/0",
                     n, bus.rdata, bus.oor_count);
        end
        idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        test_reset();
        test_clear_reads();
        test_byte_lanes();
        test_write_read();
        test_oor();
        test_back_to_back();
        test_reset_mid_sweep();
        test_reset_after_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
